// File: rtl/rptr_fwft_stage.sv
// FWFT read-side output stage of the async FIFO.
// Two-entry skid keeps rinc independent of m_ready at full rate.
module rptr_fwft_stage #(
    parameter int DATASIZE = 8
) (
    input  logic                rclk,
    input  logic                rrst_n,
    input  logic                rempty,
    input  logic [DATASIZE-1:0] rdata,
    output logic                rinc,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATASIZE-1:0] m_data,
    output logic [1:0]          m_count
);

    logic [1:0]          count_q, count_d;
    logic                valid_q, valid_d;
    logic [DATASIZE-1:0] head_q, head_d;
    logic [DATASIZE-1:0] skid_q, skid_d;
    logic                push, pop;

    // count_q[1] covers both 2 and the unreachable 3
    assign rinc    = ~rempty & ~count_q[1];
    assign push    = rinc;
    assign pop     = valid_q & m_ready;
    assign m_valid = valid_q;
    assign m_data  = head_q;
    assign m_count = count_q;

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        skid_d  = skid_q;
        unique case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = rdata;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && !pop) begin
                    skid_d  = rdata;
                    count_d = 2'd2;
                end else if (push && pop) begin
                    head_d  = rdata;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    head_d  = skid_q;
                    count_d = 2'd1;
                end
            end
        endcase
        valid_d = (count_d != 2'd0);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            count_q <= 2'd0;
            valid_q <= 1'b0;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            count_q <= count_d;
            valid_q <= valid_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

endmodule
